// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_e;
  localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/haz_lu_detect.sv
// haz_lu_detect: combinational load-use hazard comparator; index 0 never hits
module haz_lu_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             hit_o
);
  assign hit_o = ex_memread_i && (ex_rt_i != REG_W'(REG_ZERO)) &&
                 ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, taken-branch flush and MDU hold control for the 5-stage pipeline.
// PIPE_HAZ_PERF_EN adds stall/flush performance counters; otherwise both counter outputs are tied to 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_mdu_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             mem_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_bubble_sel_o,
  output logic             exmem_bubble_sel_o,
  output logic             mdu_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  localparam int CW = $clog2(MDU_LAT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] mdu_cnt_q, mdu_cnt_d;
  logic lu_hit, in_wait;
  haz_lu_detect #(.REG_W(REG_W)) u_lu (
    .ex_memread_i (ex_memread_i),
    .ex_rt_i      (ex_rt_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_uses_rt_i (id_uses_rt_i),
    .hit_o        (lu_hit)
  );
  assign in_wait = (state_q == MDU_WAIT);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end
  // Outputs are forced to RUN defaults while reset is asserted.
  always_comb begin
    state_d            = state_q;
    mdu_cnt_d          = mdu_cnt_q;
    pc_write_o         = 1'b1;
    ifid_write_o       = 1'b1;
    ifid_flush_o       = 1'b0;
    idex_write_o       = 1'b1;
    idex_bubble_sel_o  = 1'b0;
    exmem_bubble_sel_o = 1'b0;
    mdu_busy_o         = in_wait && !rst_i;
    if (!rst_i) begin
      if (mem_branch_taken_i) begin
        ifid_flush_o       = 1'b1;
        idex_bubble_sel_o  = 1'b1;
        exmem_bubble_sel_o = 1'b1;
        state_d            = RUN;
        mdu_cnt_d          = '0;
      end else if (in_wait) begin
        pc_write_o         = 1'b0;
        ifid_write_o       = 1'b0;
        idex_write_o       = 1'b0;
        exmem_bubble_sel_o = 1'b1;
        mdu_cnt_d          = mdu_cnt_q - 1'b1;
        state_d            = (mdu_cnt_q == CW'(1)) ? RUN : MDU_WAIT;
      end else if (lu_hit) begin
        pc_write_o        = 1'b0;
        ifid_write_o      = 1'b0;
        idex_bubble_sel_o = 1'b1;
      end else if (id_mdu_i && MDU_LAT > 1) begin
        state_d   = MDU_WAIT;
        mdu_cnt_d = CW'(MDU_LAT - 1);
      end
    end
  end
`ifdef PIPE_HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(!pc_write_o);
      flush_cnt_q <= flush_cnt_q + CNT_W'(mem_branch_taken_i);
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, hand sequences and randomized checks against a remaining-hold-cycles model
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5, MDU_LAT = 4, CNT_W = 32;
  logic clk = 1'b0;
  logic rst, uses, mdu, mr, tk;
  logic [REG_W-1:0] rs, rt, ert;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_b, busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;
  int wait_left = 0;
  int unsigned m_stall = 0, m_flush = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.REG_W(REG_W), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .id_rs_i(rs), .id_rt_i(rt), .id_uses_rt_i(uses), .id_mdu_i(mdu),
    .ex_memread_i(mr), .ex_rt_i(ert), .mem_branch_taken_i(tk),
    .pc_write_o(pc_w), .ifid_write_o(ifid_w), .ifid_flush_o(ifid_f), .idex_write_o(idex_w),
    .idex_bubble_sel_o(idex_b), .exmem_bubble_sel_o(exmem_b), .mdu_busy_o(busy),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );
  typedef struct {
    logic rst, mr;
    logic [4:0] ert, rs, rt;
    logic uses, mdu, tk;
    logic [6:0] exp;
    string nm;
  } vec_t;
  vec_t tab[$];
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Model: outputs from priority rules and a count of remaining hold cycles.
  function automatic logic [6:0] model_out();
    logic lu;
    lu = mr && ert != 0 && (ert == rs || (uses && ert == rt));
    if (rst) return 7'b1101000;
    if (tk) return {6'b111111, wait_left > 0};
    if (wait_left > 0) return 7'b0000011;
    if (lu) return 7'b0001100;
    return 7'b1101000;
  endfunction
  task automatic step(input vec_t v, input logic use_tab);
    logic [6:0] m;
    @(negedge clk);
    rst = v.rst; mr = v.mr; ert = v.ert; rs = v.rs; rt = v.rt; uses = v.uses; mdu = v.mdu; tk = v.tk;
    #2;
    m = model_out();
    chk({v.nm, " outs"}, {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_b, busy}, use_tab ? v.exp : m);
`ifdef PIPE_HAZ_PERF_EN
    chk({v.nm, " stall_cnt"}, stall_cnt, m_stall);
    chk({v.nm, " flush_cnt"}, flush_cnt, m_flush);
`else
    chk({v.nm, " stall_cnt"}, stall_cnt, 0);
    chk({v.nm, " flush_cnt"}, flush_cnt, 0);
`endif
    if (rst) begin
      wait_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!m[6]) m_stall++;
      if (tk) m_flush++;
      if (tk) wait_left = 0;
      else if (wait_left > 0) wait_left--;
      else if (m[6] && mdu) wait_left = MDU_LAT - 1;
    end
  endtask
  function automatic vec_t mk(input logic r, input logic m_r, input int e, input int s, input int t,
                               input logic u, input logic md, input logic b, input logic [6:0] x, input string n);
    vec_t v;
    v.rst = r; v.mr = m_r; v.ert = 5'(e); v.rs = 5'(s); v.rt = 5'(t);
    v.uses = u; v.mdu = md; v.tk = b; v.exp = x; v.nm = n;
    return v;
  endfunction
  initial begin
    vec_t v;
    rst = 1; mr = 0; ert = 0; rs = 0; rt = 0; uses = 0; mdu = 0; tk = 0;
    tab.push_back(mk(1, 1, 5, 5, 0, 0, 0, 0, 7'b1101000, "reset_defaults"));
    tab.push_back(mk(0, 1, 5, 5, 0, 0, 0, 0, 7'b0001100, "lu_rs5"));
    tab.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 7'b1101000, "lu_cleared"));
    tab.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 7'b1101000, "lu_r0"));
    tab.push_back(mk(0, 1, 7, 3, 7, 0, 0, 0, 7'b1101000, "lu_rt_unused"));
    tab.push_back(mk(0, 1, 7, 3, 7, 1, 0, 0, 7'b0001100, "lu_rt_used"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 7'b1101000, "mdu_issue"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, "mdu_wait1"));
    tab.push_back(mk(0, 1, 2, 2, 0, 0, 0, 0, 7'b0000011, "mdu_wait2_lu_ignored"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, "mdu_wait3"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b1101000, "mdu_done"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 7'b1101000, "mdu_issue_b"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, "mdu_wait_b1"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7'b1111111, "flush_in_wait"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b1101000, "after_flush_run"));
    tab.push_back(mk(0, 1, 4, 4, 0, 0, 0, 1, 7'b1111110, "flush_beats_lu"));
    tab.push_back(mk(0, 1, 5, 5, 0, 0, 1, 0, 7'b0001100, "lu_blocks_mdu"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b1101000, "no_wait_after_lu"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 7'b1101000, "mdu_issue_c"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b0000011, "mdu_wait_c1"));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 7'b1101000, "reset_mid_wait"));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7'b1101000, "run_after_reset"));
    for (int i = 0; i < tab.size(); i++) step(tab[i], 1'b1);
    // Stall/flush counter sequence: one load-use stall then a full MDU hold.
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, "seq_rst"), 1'b0);
    step(mk(0, 1, 5, 5, 0, 0, 0, 0, 0, "seq_lu"), 1'b0);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, "seq_issue"), 1'b0);
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, "seq_wait"), 1'b0);
    @(negedge clk);
`ifdef PIPE_HAZ_PERF_EN
    chk("seq_stall_total", stall_cnt, 4);
`else
    chk("seq_stall_total", stall_cnt, 0);
`endif
    chk("seq_flush_total", flush_cnt, 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, "seq_rst2"), 1'b0);
    @(negedge clk);
    chk("seq_stall_cleared", stall_cnt, 0);
    chk("seq_flush_cleared", flush_cnt, 0);
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(39) == 0, $urandom_range(1), $urandom_range(3), $urandom_range(3),
             $urandom_range(3), $urandom_range(1), $urandom_range(5) == 0, $urandom_range(9) == 0, 0, "rand");
      step(v, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
